// File: rtl/control_pkg.sv
// Shared constants for the hardwired control unit: opcodes, T-state codes,
// instruction-register field positions and the opcode-to-class decode.
package control_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_NOP  = 5'd27;
    localparam logic [4:0] OP_HALT = 5'd28;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_BINARY,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_HALT
    } op_class_e;

    // Unlisted opcodes fall through to CLS_NOP and retire after fetch.
    function automatic op_class_e op_class(input logic [4:0] op);
        op_class_e cls;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  cls = CLS_BINARY;
            OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                 cls = CLS_UNARY;
            OP_HALT:                        cls = CLS_HALT;
            OP_NOP:                         cls = CLS_NOP;
            default:                        cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_select.sv
// Register-field decoder: 4-bit register number to a one-hot strobe vector,
// forced to zero when not enabled.
module reg_select #(
    parameter int REGISTERS = 16
) (
    input  logic [3:0]           sel_i,
    input  logic                 en_i,
    output logic [REGISTERS-1:0] onehot_o
);

    assign onehot_o = en_i ? (REGISTERS'(1) << sel_i) : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state sequencer: fetch T0-T2, execute T3-T6, with every
// datapath strobe a pure decode of the current state and the IR.
module control_sequencer
    import control_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Stop,
    input  logic [BITS-1:0]      IR,
    output logic [REGISTERS-1:0] Rin,
    output logic [REGISTERS-1:0] Rout,
    output logic                 PCout,
    output logic                 PCin,
    output logic                 IncPC,
    output logic                 MARin,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 Read,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 RZin,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 HIin,
    output logic                 LOin,
    output logic                 HIout,
    output logic                 LOout,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 SHR,
    output logic                 SHL,
    output logic                 ROR,
    output logic                 ROL,
    output logic                 AND,
    output logic                 OR,
    output logic                 NEGATE,
    output logic                 NOT,
    output logic                 Run,
    output logic [3:0]           State
);

    state_e                 state_q, state_d, end_state;
    logic [4:0]             opcode;
    op_class_e              cls;
    logic                   rin_en, rb_en, rc_en, alu_go;
    logic [REGISTERS-1:0]   rout_b, rout_c;
    logic                   unused_ir;

    assign opcode    = IR[OPC_HI:OPC_LO];
    assign cls       = op_class(opcode);
    assign end_state = Stop ? S_IDLE : S_T0;
    assign unused_ir = ^IR[RC_LO-1:0];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = Stop ? S_IDLE : S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                case (cls)
                    CLS_HALT: state_d = S_HALT;
                    CLS_NOP:  state_d = end_state;
                    default:  state_d = S_T3;
                endcase
            end
            S_T3:   state_d = S_T4;
            S_T4:   state_d = (cls == CLS_BINARY || cls == CLS_MULDIV) ? S_T5 : end_state;
            S_T5:   state_d = (cls == CLS_MULDIV) ? S_T6 : end_state;
            S_T6:   state_d = end_state;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; IRin = 1'b0;
        RYin = 1'b0; RZin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
        HIin = 1'b0; LOin = 1'b0;
        rin_en = 1'b0; rb_en = 1'b0; rc_en = 1'b0; alu_go = 1'b0;
        ADD = 1'b0; SUB = 1'b0; MUL = 1'b0; DIV = 1'b0; SHR = 1'b0; SHL = 1'b0;
        ROR = 1'b0; ROL = 1'b0; AND = 1'b0; OR = 1'b0; NEGATE = 1'b0; NOT = 1'b0;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (cls == CLS_BINARY || cls == CLS_MULDIV) begin
                    rb_en = 1'b1; RYin = 1'b1;
                end else if (cls == CLS_UNARY) begin
                    rb_en = 1'b1; alu_go = 1'b1; RZin = 1'b1;
                end
            end
            S_T4: begin
                if (cls == CLS_BINARY || cls == CLS_MULDIV) begin
                    rc_en = 1'b1; alu_go = 1'b1; RZin = 1'b1;
                end else if (cls == CLS_UNARY) begin
                    Zlowout = 1'b1; rin_en = 1'b1;
                end
            end
            S_T5: begin
                if (cls == CLS_BINARY) begin
                    Zlowout = 1'b1; rin_en = 1'b1;
                end else if (cls == CLS_MULDIV) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end
            end
            S_T6: begin
                if (cls == CLS_MULDIV) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
            end
            default: ;
        endcase
        // Only one ALU select can be high because it follows the single opcode.
        if (alu_go) begin
            case (opcode)
                OP_ADD: ADD = 1'b1;
                OP_SUB: SUB = 1'b1;
                OP_MUL: MUL = 1'b1;
                OP_DIV: DIV = 1'b1;
                OP_SHR: SHR = 1'b1;
                OP_SHL: SHL = 1'b1;
                OP_ROR: ROR = 1'b1;
                OP_ROL: ROL = 1'b1;
                OP_AND: AND = 1'b1;
                OP_OR:  OR = 1'b1;
                OP_NEG: NEGATE = 1'b1;
                OP_NOT: NOT = 1'b1;
                default: ;
            endcase
        end
    end

    reg_select #(.REGISTERS(REGISTERS)) u_sel_ra (
        .sel_i(IR[RA_HI:RA_LO]), .en_i(rin_en), .onehot_o(Rin)
    );
    reg_select #(.REGISTERS(REGISTERS)) u_sel_rb (
        .sel_i(IR[RB_HI:RB_LO]), .en_i(rb_en), .onehot_o(rout_b)
    );
    reg_select #(.REGISTERS(REGISTERS)) u_sel_rc (
        .sel_i(IR[RC_HI:RC_LO]), .en_i(rc_en), .onehot_o(rout_c)
    );

    assign Rout  = rout_b | rout_c;
    assign HIout = 1'b0;
    assign LOout = 1'b0;
    assign Run   = (state_q != S_IDLE) && (state_q != S_HALT);
    assign State = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks reset, ALU, mul, unary, nop,
// Stop, mid-instruction reset and halt against hand-derived strobe patterns.
module tb_control_sequencer;

    logic        Clock, Reset, Stop;
    logic [31:0] IR;
    logic [15:0] Rin, Rout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, RYin, RZin;
    logic Zlowout, Zhighout, HIin, LOin, HIout, LOout;
    logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
    logic Run;
    logic [3:0] State;

    logic [15:0] ctl;
    logic [11:0] alu;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [15:0] K_PCOUT = 16'h8000, K_PCIN = 16'h4000, K_INCPC = 16'h2000;
    localparam logic [15:0] K_MARIN = 16'h1000, K_MDRIN = 16'h0800, K_MDROUT = 16'h0400;
    localparam logic [15:0] K_READ = 16'h0200, K_IRIN = 16'h0100, K_RYIN = 16'h0080;
    localparam logic [15:0] K_RZIN = 16'h0040, K_ZLO = 16'h0020, K_ZHI = 16'h0010;
    localparam logic [15:0] K_HIIN = 16'h0008, K_LOIN = 16'h0004;
    localparam logic [11:0] A_ADD = 12'h800, A_SUB = 12'h400, A_MUL = 12'h200;
    localparam logic [11:0] A_AND = 12'h008, A_NOT = 12'h001, A_NONE = 12'h000;

    localparam logic [15:0] F_T0 = K_PCOUT | K_MARIN | K_INCPC | K_RZIN;
    localparam logic [15:0] F_T1 = K_ZLO | K_PCIN | K_READ | K_MDRIN;
    localparam logic [15:0] F_T2 = K_MDROUT | K_IRIN;

    control_sequencer #(.BITS(32), .REGISTERS(16)) dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
        .RYin(RYin), .RZin(RZin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
        .Run(Run), .State(State)
    );

    assign ctl = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                  RYin, RZin, Zlowout, Zhighout, HIin, LOin, HIout, LOout};
    assign alu = {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT};

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] st, input logic [15:0] c,
                              input logic [11:0] a, input logic [15:0] ri, input logic [15:0] ro);
        int drivers;
        drivers = $countones(Rout) + int'(PCout) + int'(MDRout) + int'(Zlowout)
                + int'(Zhighout) + int'(HIout) + int'(LOout);
        check({tag, " state"}, 32'(State), 32'(st));
        check({tag, " ctl"}, 32'(ctl), 32'(c));
        check({tag, " alu"}, 32'(alu), 32'(a));
        check({tag, " rin"}, 32'(Rin), 32'(ri));
        check({tag, " rout"}, 32'(Rout), 32'(ro));
        check({tag, " run"}, 32'(Run), 32'((st != 4'd0) && (st != 4'd8)));
        check({tag, " one_driver"}, 32'(drivers <= 1), 32'd1);
    endtask

    task automatic fetch_t1_t2(input string tag);
        step(); expect_out({tag, " T1"}, 4'd2, F_T1, A_NONE, 16'h0, 16'h0);
        step(); expect_out({tag, " T2"}, 4'd3, F_T2, A_NONE, 16'h0, 16'h0);
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'b0};
    endfunction

    initial begin
        Reset = 1'b1;
        Stop  = 1'b0;
        IR    = 32'h4A920000;

        step(); expect_out("reset c1", 4'd0, 16'h0, A_NONE, 16'h0, 16'h0);
        step(); expect_out("reset c2", 4'd0, 16'h0, A_NONE, 16'h0, 16'h0);
        Reset = 1'b0;
        step(); expect_out("first T0", 4'd1, F_T0, A_NONE, 16'h0, 16'h0);

        // and R5,R2,R4
        fetch_t1_t2("and");
        step(); expect_out("and T3", 4'd4, K_RYIN, A_NONE, 16'h0, 16'h0004);
        step(); expect_out("and T4", 4'd5, K_RZIN, A_AND, 16'h0, 16'h0010);
        step(); expect_out("and T5", 4'd6, K_ZLO, A_NONE, 16'h0020, 16'h0);
        step(); expect_out("and next", 4'd1, F_T0, A_NONE, 16'h0, 16'h0);

        // mul R3,R4 (Rc=0)
        IR = 32'h71A00000;
        fetch_t1_t2("mul");
        step(); expect_out("mul T3", 4'd4, K_RYIN, A_NONE, 16'h0, 16'h0010);
        step(); expect_out("mul T4", 4'd5, K_RZIN, A_MUL, 16'h0, 16'h0001);
        step(); expect_out("mul T5", 4'd6, K_ZLO | K_LOIN, A_NONE, 16'h0, 16'h0);
        step(); expect_out("mul T6", 4'd7, K_ZHI | K_HIIN, A_NONE, 16'h0, 16'h0);
        step(); expect_out("mul next", 4'd1, F_T0, A_NONE, 16'h0, 16'h0);

        // not R3,R2
        IR = 32'h89900000;
        fetch_t1_t2("not");
        step(); expect_out("not T3", 4'd4, K_RZIN, A_NOT, 16'h0, 16'h0004);
        step(); expect_out("not T4", 4'd5, K_ZLO, A_NONE, 16'h0008, 16'h0);
        step(); expect_out("not next", 4'd1, F_T0, A_NONE, 16'h0, 16'h0);

        IR = mk_ir(5'd27, 4'd1, 4'd2, 4'd3);
        fetch_t1_t2("nop");
        step(); expect_out("nop next", 4'd1, F_T0, A_NONE, 16'h0, 16'h0);

        IR = mk_ir(5'd31, 4'd9, 4'd9, 4'd9);
        fetch_t1_t2("unknown");
        step(); expect_out("unknown next", 4'd1, F_T0, A_NONE, 16'h0, 16'h0);

        // add R1,R2,R3 with Stop raised in T4
        IR = mk_ir(5'd3, 4'd1, 4'd2, 4'd3);
        fetch_t1_t2("add");
        step(); expect_out("add T3", 4'd4, K_RYIN, A_NONE, 16'h0, 16'h0004);
        step(); expect_out("add T4", 4'd5, K_RZIN, A_ADD, 16'h0, 16'h0008);
        Stop = 1'b1;
        step(); expect_out("add T5 stop", 4'd6, K_ZLO, A_NONE, 16'h0002, 16'h0);
        step(); expect_out("stop idle", 4'd0, 16'h0, A_NONE, 16'h0, 16'h0);
        step(); expect_out("stop hold", 4'd0, 16'h0, A_NONE, 16'h0, 16'h0);
        Stop = 1'b0;
        step(); expect_out("resume T0", 4'd1, F_T0, A_NONE, 16'h0, 16'h0);

        // sub R6,R7,R8 interrupted by Reset between edges
        IR = mk_ir(5'd4, 4'd6, 4'd7, 4'd8);
        fetch_t1_t2("sub");
        step(); expect_out("sub T3", 4'd4, K_RYIN, A_NONE, 16'h0, 16'h0080);
        step(); expect_out("sub T4", 4'd5, K_RZIN, A_SUB, 16'h0, 16'h0100);
        #3 Reset = 1'b1;
        #1 expect_out("sub async reset", 4'd0, 16'h0, A_NONE, 16'h0, 16'h0);
        #1 Reset = 1'b0;
        step(); expect_out("after reset T0", 4'd1, F_T0, A_NONE, 16'h0, 16'h0);

        IR = 32'hE0000000;
        fetch_t1_t2("halt");
        step(); expect_out("halt enter", 4'd8, 16'h0, A_NONE, 16'h0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            Stop = i[0];
            step();
            expect_out($sformatf("halt hold %0d", i), 4'd8, 16'h0, A_NONE, 16'h0, 16'h0);
        end
        Stop = 1'b0;
        #3 Reset = 1'b1;
        #1 expect_out("halt async reset", 4'd0, 16'h0, A_NONE, 16'h0, 16'h0);
        #1 Reset = 1'b0;
        step(); expect_out("post halt T0", 4'd1, F_T0, A_NONE, 16'h0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit sitting directly upstream of the bus datapath.
- Steps the T-state sequence (fetch T0-T2, execute T3-T6) and decodes the instruction register.
- Drives every datapath strobe: register in/out selects, PC/MAR/MDR/IR/RY/RZ/HI/LO enables, memory Read, ALU op.
- Replaces the hand-sequenced stimulus currently used to exercise the datapath.

Parameters:
BITS, 32, datapath word width (IR width)
REGISTERS, 16, number of general registers (width of Rin/Rout)

Ports:
Clock  in  1  system clock, all state changes on rising edge
Reset  in  1  asynchronous, active-high; forces state IDLE
Stop  in  1  level request to pause at the next instruction boundary
IR  in  BITS  instruction register contents from datapath
Rin  out  REGISTERS  one-hot general-register load enables (R0in..R15in)
Rout  out  REGISTERS  one-hot general-register bus drivers (R0out..R15out)
PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, RYin, RZin, Zlowout, Zhighout, HIin, LOin, HIout, LOout  out  1 each  datapath strobes
ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT  out  1 each  ALU operation selects, at most one high
Run  out  1  high while sequencing (not IDLE/HALT)
State  out  4  current state code, debug only

Behaviour:
- IR fields:
  - opcode = IR[31:27]
  - Ra (dest) = IR[26:23]
  - Rb = IR[22:19]
  - Rc = IR[18:15]
  - example: 32'h4A920000 = and R5,R2,R4
- Opcodes:
  - binary ALU: add=3, sub=4, shr=5, shl=6, ror=7, rol=8, and=9, or=10
  - multiply/divide: mul=14, div=15
  - unary: neg=16, not=17
  - nop=27, halt=28
  - all others execute as nop.
- States and encoding: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8.
- Outputs are a pure decode of (state, IR). Every output not listed for a state is 0.
- Reset, including mid-instruction: state=IDLE immediately, so all outputs are 0 including Run.
- IDLE: no strobes.
  - Stop=0 -> T0
  - Stop=1 -> stay.
- Fetch (all opcodes):
  - T0: PCout, MARin, IncPC, RZin
  - T1: Zlowout, PCin, Read, MDRin
  - T2: MDRout, IRin
- IR is treated as valid only from T3. Rin/Rout are all 0 in T0-T2, IDLE and HALT.
- Binary ALU:
  - T3: Rout[Rb], RYin
  - T4: Rout[Rc], op, RZin
  - T5: Zlowout, Rin[Ra]
  - end of instruction.
- mul/div:
  - T3: Rout[Rb], RYin
  - T4: Rout[Rc], op, RZin
  - T5: Zlowout, LOin
  - T6: Zhighout, HIin
  - end of instruction.
- Unary:
  - T3: Rout[Rb], op, RZin
  - T4: Zlowout, Rin[Ra]
  - end of instruction.
- nop/unknown: end of instruction after T2.
- halt: T2 -> HALT. HALT is left only by Reset; Stop has no effect there.
- End of instruction: next state is T0 if Stop=0, IDLE if Stop=1 (sampled on that edge). Stop asserted mid-instruction never truncates the instruction.
- Latencies:
  - ALU: 6 cycles
  - mul/div: 7
  - unary: 5
  - nop: 3
- Register fields equal to each other (e.g. Ra=Rb) need no special handling: the one-hot decode is per state, so one Rout bit and one Rin bit.
- Invariant: at most one bus driver high per cycle among Rout bits, PCout, MDRout, Zlowout, Zhighout, HIout, LOout. HIout/LOout are reserved for future mfhi/mflo and are tied 0 in this revision.

Decomposition:
- Shared package control_pkg holds:
  - opcode constants (OP_ADD..OP_HALT)
  - state encodings (S_IDLE..S_HALT)
  - IR field bit positions
- One sub-module, reg_select: 4-bit field -> REGISTERS-wide one-hot with enable.
  - Instantiated three times, for Ra->Rin, Rb->Rout, and Rc->Rout.
  - The two Rout instances are ORed; their enables are never simultaneous.

Test Plan:
- Reset=1 for 2 cycles then 0, Stop=0: outputs all 0 and State=0 during reset; the following edge gives State=1 with PCout, MARin, IncPC, RZin high.
- IR=32'h4A920000 (and R5,R2,R4):
  - T3: Rout=16'h0004 and RYin
  - T4: Rout=16'h0010, AND, RZin
  - T5: Zlowout and Rin=16'h0020
  - next edge: T0.
- IR=32'h71A00000 (mul R3,R4; opcode 14):
  - T5: Zlowout, LOin
  - T6: Zhighout, HIin
  - Rin stays 0 throughout
  - 7-cycle period confirmed.
- IR=32'h89900000 (not R3,R2; opcode 17):
  - T3: Rout=16'h0004, NOT, RZin
  - T4: Rin=16'h0008
  - return to T0 after 5 cycles.
- Stop raised during T4 of an add: the instruction completes through T5, then State=0 with Run=0; Stop lowered -> T0 on the next edge.
- IR=32'hE0000000 (halt): after T2, State=8, Run=0, outputs 0 for 10 cycles. Then Reset asserted mid-cycle: State=0 asynchronously, before the next clock edge.
